// File: rtl/vout_pkg.sv
// Shared definitions for the video output mode controller: default field widths,
// controller state encoding and the mode sanity check.
package vout_pkg;

   localparam int unsigned HFP_W_DEF     = 8;
   localparam int unsigned HSW_W_DEF     = 4;
   localparam int unsigned HBP_W_DEF     = 8;
   localparam int unsigned HACTIVE_W_DEF = 16;
   localparam int unsigned VFP_W_DEF     = 8;
   localparam int unsigned VSW_W_DEF     = 4;
   localparam int unsigned VBP_W_DEF     = 8;
   localparam int unsigned VACTIVE_W_DEF = 16;

   localparam logic [2:0] ST_OFF       = 3'd0;
   localparam logic [2:0] ST_RUN       = 3'd1;
   localparam logic [2:0] ST_PEND      = 3'd2;
   localparam logic [2:0] ST_QUIET     = 3'd3;
   localparam logic [2:0] ST_LOAD      = 3'd4;
   localparam logic [2:0] ST_QUIET_OFF = 3'd5;

   // A timing generator cannot run with an empty active area or a zero-width sync.
   function automatic logic mode_valid(input logic [31:0] hactive, input logic [31:0] vactive,
                                       input logic [31:0] hsw, input logic [31:0] vsw);
      return (hactive != 32'd0) && (vactive != 32'd0) && (hsw != 32'd0) && (vsw != 32'd0);
   endfunction

endpackage

// File: rtl/vout_timing_shadow.sv
// Shadow/active register pair: cap latches an offered set, load promotes it to the
// active outputs.
module vout_timing_shadow #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cap,
   input  logic         load,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] shadow_q;
   logic [W-1:0] active_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (cap) shadow_q <= din;
         // Capture and load in the same cycle happen on the direct OFF -> LOAD path.
         if (load) active_q <= cap ? din : shadow_q;
      end
   end

   assign dout = active_q;

endmodule

// File: rtl/vout_timing_ctrl.sv
// Run-time mode controller for the video output timing generator: accepts, validates
// and atomically applies new timing sets at frame boundaries.
module vout_timing_ctrl
   import vout_pkg::*;
#(
   parameter int unsigned HFP_WIDTH     = HFP_W_DEF,
   parameter int unsigned HSW_WIDTH     = HSW_W_DEF,
   parameter int unsigned HBP_WIDTH     = HBP_W_DEF,
   parameter int unsigned HACTIVE_WIDTH = HACTIVE_W_DEF,
   parameter int unsigned VFP_WIDTH     = VFP_W_DEF,
   parameter int unsigned VSW_WIDTH     = VSW_W_DEF,
   parameter int unsigned VBP_WIDTH     = VBP_W_DEF,
   parameter int unsigned VACTIVE_WIDTH = VACTIVE_W_DEF,
   parameter int unsigned QUIET_CYC     = 4,
   parameter int unsigned TMO_WIDTH     = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable_i,
   input  logic                     cfg_valid_i,
   output logic                     cfg_ready_o,
   input  logic                     cfg_hpol_i,
   input  logic [HFP_WIDTH-1:0]     cfg_hfp_i,
   input  logic [HSW_WIDTH-1:0]     cfg_hsw_i,
   input  logic [HBP_WIDTH-1:0]     cfg_hbp_i,
   input  logic [HACTIVE_WIDTH-1:0] cfg_hactive_i,
   input  logic [VFP_WIDTH-1:0]     cfg_vfp_i,
   input  logic [VSW_WIDTH-1:0]     cfg_vsw_i,
   input  logic [VBP_WIDTH-1:0]     cfg_vbp_i,
   input  logic [VACTIVE_WIDTH-1:0] cfg_vactive_i,
   input  logic                     frame_end_i,
   output logic                     hpol_o,
   output logic [HFP_WIDTH-1:0]     hfp_o,
   output logic [HSW_WIDTH-1:0]     hsw_o,
   output logic [HBP_WIDTH-1:0]     hbp_o,
   output logic [HACTIVE_WIDTH-1:0] hactive_o,
   output logic [VFP_WIDTH-1:0]     vfp_o,
   output logic [VSW_WIDTH-1:0]     vsw_o,
   output logic [VBP_WIDTH-1:0]     vbp_o,
   output logic [VACTIVE_WIDTH-1:0] vactive_o,
   output logic                     sync_en_o,
   output logic                     busy_o,
   output logic                     cfg_err_o,
   output logic                     tmo_o
);

   localparam int unsigned SET_W  = 1 + HFP_WIDTH + HSW_WIDTH + HBP_WIDTH + HACTIVE_WIDTH +
                                    VFP_WIDTH + VSW_WIDTH + VBP_WIDTH + VACTIVE_WIDTH;
   localparam int unsigned QCNT_W = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
   localparam logic [QCNT_W-1:0] QCNT_START = QCNT_W'(QUIET_CYC - 1);

   logic [2:0]           state_q, state_d;
   logic [QCNT_W-1:0]    qcnt_q, qcnt_d;
   logic [TMO_WIDTH-1:0] wdog_q, wdog_d;
   logic                 loaded_q;
   logic                 err_q;
   logic                 tmo_q, tmo_d;
   logic                 xfer, accept, load;
   logic [SET_W-1:0]     cfg_set, active_set;

   assign cfg_ready_o = (state_q == ST_OFF) || (state_q == ST_RUN);
   assign xfer        = cfg_valid_i && cfg_ready_o;
   assign accept      = xfer && mode_valid(32'(cfg_hactive_i), 32'(cfg_vactive_i),
                                           32'(cfg_hsw_i), 32'(cfg_vsw_i));

   always_comb begin
      state_d = state_q;
      qcnt_d  = qcnt_q;
      wdog_d  = wdog_q;
      tmo_d   = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (accept) state_d = ST_LOAD;
            else if (enable_i && loaded_q) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (accept) begin
               state_d = ST_PEND;
               // Starting at 1 makes the all-ones check fire 2**TMO_WIDTH-1 cycles on.
               wdog_d  = TMO_WIDTH'(1);
            end else if (!enable_i) begin
               state_d = ST_QUIET_OFF;
               qcnt_d  = QCNT_START;
            end
         end
         ST_PEND: begin
            wdog_d = wdog_q + TMO_WIDTH'(1);
            if (frame_end_i || (&wdog_q) || !enable_i) begin
               state_d = ST_QUIET;
               qcnt_d  = QCNT_START;
               tmo_d   = (&wdog_q) && !frame_end_i;
            end
         end
         ST_QUIET: begin
            if (qcnt_q == '0) state_d = ST_LOAD;
            else qcnt_d = qcnt_q - QCNT_W'(1);
         end
         ST_LOAD: state_d = enable_i ? ST_RUN : ST_OFF;
         ST_QUIET_OFF: begin
            if (qcnt_q == '0) state_d = ST_OFF;
            else qcnt_d = qcnt_q - QCNT_W'(1);
         end
         default: state_d = ST_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_OFF;
         qcnt_q   <= '0;
         wdog_q   <= '0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         qcnt_q   <= qcnt_d;
         wdog_q   <= wdog_d;
         loaded_q <= loaded_q || load;
         err_q    <= xfer && !accept;
         tmo_q    <= tmo_d;
      end
   end

   // Active set updates on entry to LOAD so it is visible while sync_en_o is still low.
   assign load    = (state_d == ST_LOAD);
   assign cfg_set = {cfg_hpol_i, cfg_hfp_i, cfg_hsw_i, cfg_hbp_i, cfg_hactive_i,
                     cfg_vfp_i, cfg_vsw_i, cfg_vbp_i, cfg_vactive_i};

   vout_timing_shadow #(
      .W (SET_W)
   ) u_shadow (
      .clk  (clk),
      .rst  (rst),
      .cap  (accept),
      .load (load),
      .din  (cfg_set),
      .dout (active_set)
   );

   assign {hpol_o, hfp_o, hsw_o, hbp_o, hactive_o, vfp_o, vsw_o, vbp_o, vactive_o} = active_set;

   assign sync_en_o = (state_q == ST_RUN) || (state_q == ST_PEND);
   assign busy_o    = (state_q == ST_PEND) || (state_q == ST_QUIET) || (state_q == ST_LOAD);
   assign cfg_err_o = err_q;
   assign tmo_o     = tmo_q;

endmodule
